seq_alu: RTL and testbench

//  Multi-cycle ALU directly downstream of reg_file: consumes ReadA/ReadB, writes the result back via writeValue/RegWrite.

---
 rtl/ark_pkg.sv | 23 ++
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_mul.sv | 45 ++++
 rtl/seq_alu.sv | 159 +++++++++++++++
 tb/tb_seq_alu.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/ark_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package ark_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } seq_alu_state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between reg_file read ports, the ALU and the write-back port.
interface seq_alu_if
    import ark_pkg::*;
#(
    parameter int W = 8
);

    logic          Start;
    alu_op_t       Op;
    logic [W-1:0]  OpA;
    logic [W-1:0]  OpB;
    logic [1:0]    DestSel;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  writeValue;
    logic [1:0]    RegWrite;
    logic          Carry;
    logic          Zero;

    modport master (
        output Start, Op, OpA, OpB, DestSel,
        input  Busy, Done, writeValue, RegWrite, Carry, Zero
    );

    modport slave (
        input  Start, Op, OpA, OpB, DestSel,
        output Busy, Done, writeValue, RegWrite, Carry, Zero
    );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per i_step, o_last on the final step.
module seq_alu_mul #(
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_step,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_last,
    output logic [2*W-1:0] o_acc_nxt
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_acc;
    logic [2*W-1:0]   w_addend;

    // o_acc_nxt includes the current step so the top can latch the product on the last edge.
    assign w_addend  = (2*W)'(r_a) << r_cnt;
    assign o_acc_nxt = r_b[r_cnt] ? (r_acc + w_addend) : r_acc;
    assign o_last    = i_step && (r_cnt == CNT_W'(W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= o_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU feeding reg_file write-back; Start/Busy/Done handshake.
// SEQ_ALU_MUL_EN: enables the MUL state and shift-add multiplier; otherwise Op=7 is a suppressed write.
module seq_alu
    import ark_pkg::*;
#(
    parameter int W = 8
) (
    input  logic     CLK,
    input  logic     Reset_n,
    seq_alu_if.slave bus
);

    seq_alu_state_t r_state;
    seq_alu_state_t w_state_nxt;

    logic [W-1:0]   r_result;
    logic [1:0]     r_reg_write;
    logic           r_carry;
    logic           r_zero;

    logic           w_accept;
    logic [W-1:0]   w_res;
    logic           w_carry;
    logic           w_busy;
    logic           w_done;

    assign w_accept = (r_state == IDLE) && bus.Start;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (bus.Op)
            ALU_ADD: {w_carry, w_res} = {1'b0, bus.OpA} + {1'b0, bus.OpB};
            ALU_SUB: begin
                w_res   = bus.OpA - bus.OpB;
                w_carry = (bus.OpA < bus.OpB);
            end
            ALU_AND: w_res = bus.OpA & bus.OpB;
            ALU_OR:  w_res = bus.OpA | bus.OpB;
            ALU_XOR: w_res = bus.OpA ^ bus.OpB;
            ALU_SHL: begin
                w_res   = {bus.OpA[W-2:0], 1'b0};
                w_carry = bus.OpA[W-1];
            end
            ALU_SHR: begin
                w_res   = {1'b0, bus.OpA[W-1:1]};
                w_carry = bus.OpA[0];
            end
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic [1:0]     r_dest;
    logic           w_mul_last;
    logic [2*W-1:0] w_mul_acc;

    seq_alu_mul #(.W(W)) u_mul (
        .i_clk     (CLK),
        .i_rst_n   (Reset_n),
        .i_start   (w_accept && (bus.Op == ALU_MUL)),
        .i_step    (r_state == MUL),
        .i_a       (bus.OpA),
        .i_b       (bus.OpB),
        .o_last    (w_mul_last),
        .o_acc_nxt (w_mul_acc)
    );
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
`ifdef SEQ_ALU_MUL_EN
                    w_state_nxt = (bus.Op == ALU_MUL) ? MUL : WB;
`else
                    w_state_nxt = WB;
`endif
                end
            end
            MUL: begin
`ifdef SEQ_ALU_MUL_EN
                if (w_mul_last) begin
                    w_state_nxt = WB;
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            WB:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
        w_done = (r_state == WB);
    end

    // NOTE: sequential state uses non-blocking assignments only; RegWrite defaults low every edge.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_result    <= '0;
            r_reg_write <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_dest      <= '0;
`endif
        end else begin
            r_reg_write <= '0;
            if (w_accept) begin
                if (bus.Op != ALU_MUL) begin
                    r_result    <= w_res;
                    r_carry     <= w_carry;
                    r_zero      <= (w_res == '0);
                    r_reg_write <= bus.DestSel;
                end else begin
`ifdef SEQ_ALU_MUL_EN
                    r_dest      <= bus.DestSel;
`else
                    r_result    <= '0;
                    r_carry     <= 1'b0;
                    r_zero      <= 1'b1;
`endif
                end
            end
`ifdef SEQ_ALU_MUL_EN
            if ((r_state == MUL) && w_mul_last) begin
                r_result    <= w_mul_acc[W-1:0];
                r_carry     <= |w_mul_acc[2*W-1:W];
                r_zero      <= (w_mul_acc[W-1:0] == '0);
                r_reg_write <= r_dest;
            end
`endif
        end
    end

    assign bus.Busy       = w_busy;
    assign bus.Done       = w_done;
    assign bus.writeValue = r_result;
    assign bus.RegWrite   = r_reg_write;
    assign bus.Carry      = r_carry;
    assign bus.Zero       = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (W=8), covering both SEQ_ALU_MUL_EN builds.
module tb_seq_alu;
    import ark_pkg::*;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    seq_alu_if #(.W(W)) bus ();

    seq_alu #(.W(W)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic launch(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] d);
        bus.Start   = 1'b1;
        bus.Op      = op;
        bus.OpA     = a;
        bus.OpB     = b;
        bus.DestSel = d;
        tick();
        bus.Start   = 1'b0;
    endtask

    // Called in the WB cycle; checks it, then the following idle cycle.
    task automatic check_wb(input string tag, input logic [7:0] v, input logic [1:0] rw,
                            input logic c, input logic z);
        check({tag, ".done"},  bus.Done, 1'b1);
        check({tag, ".busy"},  bus.Busy, 1'b1);
        check({tag, ".value"}, bus.writeValue, v);
        check({tag, ".rw"},    bus.RegWrite, rw);
        check({tag, ".carry"}, bus.Carry, c);
        check({tag, ".zero"},  bus.Zero, z);
        tick();
        check({tag, ".done_off"}, bus.Done, 1'b0);
        check({tag, ".rw_off"},   bus.RegWrite, 2'd0);
        check({tag, ".idle"},     bus.Busy, 1'b0);
        check({tag, ".held"},     bus.writeValue, v);
    endtask

    initial begin
        Reset_n     = 1'b0;
        bus.Start   = 1'b0;
        bus.Op      = ALU_ADD;
        bus.OpA     = '0;
        bus.OpB     = '0;
        bus.DestSel = '0;
        #12;
        check("rst.busy",  bus.Busy, 1'b0);
        check("rst.done",  bus.Done, 1'b0);
        check("rst.rw",    bus.RegWrite, 2'd0);
        check("rst.value", bus.writeValue, 8'h00);
        check("rst.carry", bus.Carry, 1'b0);
        check("rst.zero",  bus.Zero, 1'b0);
        @(negedge CLK);
        Reset_n = 1'b1;
        tick();
        check("idle.busy", bus.Busy, 1'b0);

        launch(ALU_ADD, 8'h7F, 8'h01, 2'd1);
        check_wb("add", 8'h80, 2'd1, 1'b0, 1'b0);
        launch(ALU_SUB, 8'h05, 8'h07, 2'd2);
        check_wb("sub_borrow", 8'hFE, 2'd2, 1'b1, 1'b0);
        launch(ALU_SHL, 8'h81, 8'h00, 2'd1);
        check_wb("shl", 8'h02, 2'd1, 1'b1, 1'b0);
        launch(ALU_ADD, 8'hFF, 8'h01, 2'd3);
        check_wb("add_wrap", 8'h00, 2'd3, 1'b1, 1'b1);
        launch(ALU_SUB, 8'h07, 8'h05, 2'd2);
        check_wb("sub", 8'h02, 2'd2, 1'b0, 1'b0);
        launch(ALU_AND, 8'hF0, 8'h3C, 2'd1);
        check_wb("and", 8'h30, 2'd1, 1'b0, 1'b0);
        launch(ALU_OR, 8'hF0, 8'h0F, 2'd2);
        check_wb("or", 8'hFF, 2'd2, 1'b0, 1'b0);
        launch(ALU_XOR, 8'hAA, 8'hAA, 2'd3);
        check_wb("xor_zero", 8'h00, 2'd3, 1'b0, 1'b1);
        launch(ALU_XOR, 8'hA5, 8'h0F, 2'd1);
        check_wb("xor", 8'hAA, 2'd1, 1'b0, 1'b0);
        launch(ALU_SHR, 8'h81, 8'h00, 2'd1);
        check_wb("shr", 8'h40, 2'd1, 1'b1, 1'b0);

`ifndef SEQ_ALU_MUL_EN
        launch(ALU_MUL, 8'h03, 8'h04, 2'd1);
        check_wb("mul_off", 8'h00, 2'd0, 1'b0, 1'b1);
`endif

        launch(ALU_ADD, 8'h10, 8'h22, 2'd0);
        check_wb("dest0", 8'h32, 2'd0, 1'b0, 1'b0);

        // Start held through the WB cycle must not launch a second operation.
        bus.Start   = 1'b1;
        bus.Op      = ALU_ADD;
        bus.OpA     = 8'h01;
        bus.OpB     = 8'h02;
        bus.DestSel = 2'd1;
        tick();
        bus.Op  = ALU_XOR;
        bus.OpA = 8'hFF;
        bus.OpB = 8'h0F;
        check("wbstart.done",  bus.Done, 1'b1);
        check("wbstart.value", bus.writeValue, 8'h03);
        tick();
        bus.Start = 1'b0;
        check("wbstart.busy",  bus.Busy, 1'b0);
        check("wbstart.done2", bus.Done, 1'b0);
        check("wbstart.held",  bus.writeValue, 8'h03);
        tick();
        check("wbstart.quiet", bus.Done, 1'b0);

        // Reset asserted during WB clears everything immediately.
        launch(ALU_SUB, 8'h10, 8'h01, 2'd3);
        check("rstwb.pre", bus.Done, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("rstwb.done",  bus.Done, 1'b0);
        check("rstwb.rw",    bus.RegWrite, 2'd0);
        check("rstwb.busy",  bus.Busy, 1'b0);
        check("rstwb.value", bus.writeValue, 8'h00);
        @(negedge CLK);
        Reset_n = 1'b1;
        tick();
        launch(ALU_ADD, 8'h02, 8'h03, 2'd2);
        check_wb("post_rst", 8'h05, 2'd2, 1'b0, 1'b0);

`ifdef SEQ_ALU_MUL_EN
        // MUL latency, with an ADD request pulsed mid-operation.
        launch(ALU_MUL, 8'h0C, 8'h0B, 2'd2);
        for (int i = 0; i < 8; i++) begin
            check("mul.busy", bus.Busy, 1'b1);
            check("mul.nodone", bus.Done, 1'b0);
            bus.Start = (i == 3);
            bus.Op    = ALU_ADD;
            bus.OpA   = 8'h01;
            bus.OpB   = 8'h01;
            tick();
        end
        bus.Start = 1'b0;
        check_wb("mul", 8'h84, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("mul.single_done", bus.Done, 1'b0);
            tick();
        end

        launch(ALU_MUL, 8'h20, 8'h10, 2'd1);
        repeat (8) tick();
        check_wb("mul_ovf", 8'h00, 2'd1, 1'b1, 1'b1);

        // Reset after four multiply steps aborts without a write.
        launch(ALU_MUL, 8'h0F, 8'h0F, 2'd3);
        repeat (4) tick();
        check("mulrst.pre", bus.Busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("mulrst.busy", bus.Busy, 1'b0);
        check("mulrst.rw",   bus.RegWrite, 2'd0);
        check("mulrst.done", bus.Done, 1'b0);
        @(negedge CLK);
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mulrst.nodone", bus.Done, 1'b0);
        end
        launch(ALU_ADD, 8'h01, 8'h01, 2'd1);
        check_wb("mulrst.after", 8'h02, 2'd1, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
